// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase/dwell checker on the crossing lamp bus
module traffic_light_monitor #(
    parameter int GREEN_T  = 25,
    parameter int YELLOW_T = 5
) (
    input  logic       CLK1Hz,
    input  logic       nRST,
    input  logic [7:0] led_in,
    output logic       locked,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] phase,
    output logic [5:0] dwell,
    output logic [7:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_BAD_SEQ  = 3'd3;
    localparam logic [2:0] FC_SHORT    = 3'd4;
    localparam logic [2:0] FC_LONG     = 3'd5;
    localparam logic [2:0] FC_DARK     = 3'd6;

    localparam logic [5:0] GREEN_W  = 6'(GREEN_T);
    localparam logic [5:0] YELLOW_W = 6'(YELLOW_T);

    state_t     state, state_n;
    logic [7:0] prev_pat;
    logic [2:0] code_n;
    logic [1:0] phase_n;
    logic [7:0] cnt_n;
    logic [5:0] dwell_n;

    logic [2:0] road_a, road_b;
    logic       one_a, one_b;
    logic       is_dark, is_conflict, is_phase, is_illegal;
    logic [1:0] pat_phase;
    logic [5:0] expected;
    logic [1:0] succ;

    always_comb begin
        road_a      = led_in[2:0];
        road_b      = led_in[7:5];
        one_a       = (road_a == 3'b100) || (road_a == 3'b010) || (road_a == 3'b001);
        one_b       = (road_b == 3'b100) || (road_b == 3'b010) || (road_b == 3'b001);
        is_dark     = (led_in == 8'h00);
        is_conflict = one_a && one_b && !road_a[2] && !road_b[2];
        is_phase    = 1'b1;
        pat_phase   = 2'd0;
        case (led_in)
            8'b001_00_100: pat_phase = 2'd0;
            8'b010_00_100: pat_phase = 2'd1;
            8'b100_00_001: pat_phase = 2'd2;
            8'b100_00_010: pat_phase = 2'd3;
            default:       is_phase  = 1'b0;
        endcase
        is_illegal = !is_dark && !is_conflict && !is_phase;
        expected   = phase[0] ? YELLOW_W : GREEN_W;
        succ       = phase + 2'd1;
        if (led_in != prev_pat)
            dwell_n = 6'd1;
        else if (dwell == 6'd63)
            dwell_n = 6'd63;
        else
            dwell_n = dwell + 6'd1;
    end

    always_comb begin
        state_n = state;
        code_n  = fault_code;
        phase_n = phase;
        cnt_n   = cycle_cnt;
        // Decode-level faults outrank every sequencing fault on the same edge
        if (state != S_FAULT && is_conflict) begin
            state_n = S_FAULT;
            code_n  = FC_CONFLICT;
        end else if (state != S_FAULT && is_illegal) begin
            state_n = S_FAULT;
            code_n  = FC_ILLEGAL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_phase) begin
                        state_n = S_ACQUIRE;
                        phase_n = pat_phase;
                    end
                end
                S_ACQUIRE: begin
                    if (is_dark) begin
                        state_n = S_IDLE;
                    end else if (pat_phase == phase) begin
                        if (dwell >= GREEN_W) begin
                            state_n = S_FAULT;
                            code_n  = FC_LONG;
                        end
                    end else if (pat_phase == succ) begin
                        state_n = S_TRACK;
                        phase_n = pat_phase;
                    end else begin
                        state_n = S_FAULT;
                        code_n  = FC_BAD_SEQ;
                    end
                end
                S_TRACK: begin
                    if (is_dark) begin
                        state_n = S_FAULT;
                        code_n  = FC_DARK;
                    end else if (pat_phase == phase) begin
                        if (dwell >= expected) begin
                            state_n = S_FAULT;
                            code_n  = FC_LONG;
                        end
                    end else if (pat_phase != succ) begin
                        state_n = S_FAULT;
                        code_n  = FC_BAD_SEQ;
                    end else if (dwell < expected) begin
                        state_n = S_FAULT;
                        code_n  = FC_SHORT;
                    end else begin
                        phase_n = pat_phase;
                        if (phase == 2'd3)
                            cnt_n = cycle_cnt + 8'd1;
                    end
                end
                default: begin
                    // Only a dark bus (controller held in reset) clears a fault
                    if (is_dark) begin
                        state_n = S_IDLE;
                        code_n  = FC_NONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK1Hz or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            prev_pat   <= 8'h00;
            fault_code <= FC_NONE;
            phase      <= 2'd0;
            dwell      <= 6'd0;
            cycle_cnt  <= 8'd0;
        end else begin
            state      <= state_n;
            prev_pat   <= led_in;
            fault_code <= code_n;
            phase      <= phase_n;
            dwell      <= dwell_n;
            cycle_cnt  <= cnt_n;
        end
    end

    assign locked = (state == S_TRACK);
    assign fault  = (state == S_FAULT);

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the 8-bit traffic-light lamp bus driven by the crossing controller. It samples the bus once per second and decodes each road's lamp state. It tracks the four-phase cycle and checks phase order and dwell times, then reports lock, phase, dwell and a sticky fault code. It sits beside the controller on the board or in the bench, and drives nothing back into it.

Parameters:
GREEN_T, 25, required green dwell in samples (1..62)
YELLOW_T, 5, required yellow dwell in samples (1..62)

Ports:
CLK1Hz  input  1  sample clock, rising edge
nRST  input  1  asynchronous, active-low reset
led_in  input  8  lamp bus: [7:5] road B, [4:3] spare (must be 00), [2:0] road A; per road 100=red, 010=yellow, 001=green
locked  output  1  1 while in TRACK
fault  output  1  1 while in FAULT
fault_code  output  3  0 none, 1 ILLEGAL, 2 CONFLICT, 3 BAD_SEQ, 4 SHORT, 5 LONG, 6 DARK_LOSS
phase  output  2  current phase id (valid in ACQUIRE/TRACK)
dwell  output  6  consecutive samples of current pattern, saturates at 63
cycle_cnt  output  8  completed cycles (P3->P0 in TRACK), wraps 255->0

Behaviour:
- Reset (nRST=0, async): state=IDLE; all outputs 0; internal prev-pattern register 0.
- Decode of led_in each rising edge:
  - P0: A red, B green.
  - P1: A red, B yellow.
  - P2: A green, B red.
  - P3: A yellow, B red.
  - DARK: 8'h00.
  - CONFLICT: neither road red, and each road shows exactly one lamp.
  - ILLEGAL: anything else, e.g. multiple lamps on one road, one road dark, or led_in[4:3]!=0.
- Expected dwell: P0/P2=GREEN_T, P1/P3=YELLOW_T. Legal successor: (phase+1) mod 4.
- Dwell counter: pattern differs from prev -> dwell<=1; same -> dwell<=min(dwell+1,63). Checks use dwell before update.
- Latency: all outputs registered; a bad sample is flagged at the same edge that samples it.
- Fault priority (highest first): CONFLICT > ILLEGAL > DARK_LOSS > BAD_SEQ > SHORT > LONG.
- IDLE:
  - DARK -> stay.
  - Phase Pn -> ACQUIRE, phase=n, dwell=1.
  - CONFLICT/ILLEGAL -> FAULT.
- ACQUIRE (first phase may be partial, so no SHORT check):
  - Same phase -> count; dwell reaching GREEN_T+1 -> FAULT LONG.
  - Legal successor -> TRACK, phase updated, dwell=1.
  - Non-successor phase -> FAULT BAD_SEQ.
  - DARK -> IDLE.
  - CONFLICT/ILLEGAL -> FAULT.
- TRACK:
  - Same phase: count; dwell reaching expected+1 -> FAULT LONG.
  - Change to legal successor with old dwell==expected -> advance phase, dwell=1; P3->P0 also increments cycle_cnt.
  - Change with old dwell<expected -> FAULT SHORT.
  - Non-successor -> FAULT BAD_SEQ.
  - DARK -> FAULT DARK_LOSS.
- FAULT:
  - Sticky: fault_code, phase and cycle_cnt frozen; dwell keeps counting the current pattern.
  - Exit only on a DARK sample (controller held in reset) -> IDLE, fault_code=0. Or via nRST.
- Simultaneous events: one fault per edge, chosen by priority. A conflict sampled on the same edge as a phase change reports CONFLICT.
- cycle_cnt is cleared only by nRST; it is not cleared on IDLE re-entry.
- Reset mid-operation: immediate async return to reset values. The first edge after release re-decodes led_in from IDLE.

Test Plan:
1. 3 DARK samples, then P0x25, P1x5, P2x25, P3x5, repeated 3 cycles, then one P0 sample -> locked=1 from the first P1 sample, fault=0 throughout, cycle_cnt=3 at end, dwell peaks at 25/5.
2. Locked, then P1 held 4 samples followed by P2 -> fault=1, fault_code=4, phase stays 1; then led_in=00 -> IDLE, fault=0, locked=0.
3. Locked, then P2 held 26 samples -> fault_code=5 on the 26th P2 sample, locked=0.
4. In IDLE and again in TRACK, led_in=8'b001_00_001 (both green) -> fault_code=2 on that edge; 8'b100_10_001 -> fault_code=1.
5. Locked in P0 (full dwell), then P2 -> fault_code=3; while in FAULT, P3 sampled -> code unchanged; then DARK -> IDLE, code 0.
6. Locked mid-P2 with cycle_cnt=2, then nRST pulsed low -> all outputs 0 immediately. A P2 sample after release -> ACQUIRE, locked=0, phase=2, dwell=1.
